// File: rtl/bin_inv_sched.sv
// Round-robin scheduler that time-shares one combinational inverter cell among NUM_REQ requesters.
// Define BIN_INV_SCHED_CHECK_EN to build a sticky result checker on chk_err (tied to 0 otherwise).
module bin_inv_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 2,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         inv_in,
  input  logic [WIDTH-1:0]         inv_out,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic                     rsp_ready,
  output logic                     busy,
  output logic                     chk_err
);
  localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("bin_inv_sched: NUM_REQ must be >= 2");
  end
  if (ID_W < PTR_W) begin : g_bad_id_w
    $error("bin_inv_sched: ID_W too narrow for NUM_REQ");
  end

  typedef enum logic [1:0] {IDLE, DRIVE, CAPT, RESP} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   cur_id_q, cur_id_d;
  logic [WIDTH-1:0]   inv_in_q, inv_in_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_id;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               xfer;

  // First valid requester at or after rr_ptr, wrapping to 0.
  always_comb begin : rr_search
    int idx;
    logic [PTR_W-1:0] sel;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PTR_W'(idx);
      if (!gnt_any && req_valid[sel]) begin
        gnt_any = 1'b1;
        gnt_id  = sel;
      end
    end
    gnt_oh         = '0;
    gnt_oh[gnt_id] = 1'b1;
  end

  assign xfer = (state_q == IDLE) && gnt_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      inv_in_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      inv_in_q    <= inv_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    inv_in_d    = inv_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      IDLE: if (xfer) begin
        inv_in_d = req_data[int'(gnt_id)*WIDTH +: WIDTH];
        cur_id_d = gnt_id;
        rr_ptr_d = (int'(gnt_id) + 1 == NUM_REQ) ? '0 : PTR_W'(gnt_id + 1'b1);
        state_d  = DRIVE;
      end
      DRIVE: state_d = CAPT;
      CAPT: begin
        rsp_data_d  = inv_out;
        rsp_id_d    = ID_W'(cur_id_q);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    req_ready = '0;
    if (xfer && rst_n) req_ready = gnt_oh;
    busy      = (state_q != IDLE);
    inv_in    = inv_in_q;
    rsp_valid = rsp_valid_q;
    rsp_id    = rsp_id_q;
    rsp_data  = rsp_data_q;
  end

`ifdef BIN_INV_SCHED_CHECK_EN
  logic chk_err_q, chk_err_d;

  always_comb begin
    chk_err_d = chk_err_q;
    if (state_q == CAPT && inv_out != ~inv_in_q) chk_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err_q <= 1'b0;
    else        chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_bin_inv_sched.sv
// Scoreboard bench for bin_inv_sched: a cycle-level transaction model predicts grants,
// busy/valid windows and responses; a separate monitor pops and checks each response.
module tb_bin_inv_sched;
  localparam int NR = 4;
  localparam int W  = 2;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [W-1:0]    inv_in, inv_out;
  logic            rsp_valid, rsp_ready, busy, chk_err;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_data;
  logic            fault;

  bin_inv_sched #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .inv_in(inv_in), .inv_out(inv_out), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy),
    .chk_err(chk_err)
  );

  // Shared inverter cell; fault mode sticks bit 0 at 0.
  assign inv_out = fault ? (~inv_in & 2'b10) : ~inv_in;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { int id; int data; } exp_t;
  exp_t sbq[$];

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  // Transaction model: phase 0 idle, 1 operand driven, 2 capture, 3 response held.
  int phase = 0, ptr = 0, exp_inv = 0, pick = 0, exp_rdy = 0, d = 0;
  bit exp_chk = 0, pend_mis = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0; ptr = 0; exp_inv = 0; exp_chk = 0; pend_mis = 0;
      sbq.delete();
    end else begin
      pick    = (phase == 0) ? rr_pick(req_valid, ptr) : -1;
      exp_rdy = (pick >= 0) ? (1 << pick) : 0;
      check("req_ready", int'(req_ready), exp_rdy);
      check("busy", int'(busy), int'(phase != 0));
      check("rsp_valid", int'(rsp_valid), int'(phase == 3));
      check("inv_in", int'(inv_in), exp_inv);
      check("chk_err", int'(chk_err), int'(exp_chk));
      case (phase)
        0: if (pick >= 0) begin
          d = int'(req_data >> (pick * W)) & 3;
          exp_inv = d;
          sbq.push_back('{pick, fault ? ((~d) & 2) : ((~d) & 3)});
          pend_mis = fault && (((~d) & 1) != 0);
          ptr = (pick + 1) % NR;
          phase = 1;
        end
        1: phase = 2;
        2: begin
          phase = 3;
`ifdef BIN_INV_SCHED_CHECK_EN
          if (pend_mis) exp_chk = 1'b1;
`endif
        end
        default: if (rsp_ready) phase = 0;
      endcase
    end
  end

  // Response monitor, independent of the stimulus.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sbq.size() == 0) check("sb_nonempty", sbq.size(), 1);
      else begin
        check("rsp_id", int'(rsp_id), sbq[0].id);
        check("rsp_data", int'(rsp_data), sbq[0].data);
        if (rsp_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic check_reset_outs();
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    check("rst_rsp_data", int'(rsp_data), 0);
    check("rst_inv_in", int'(inv_in), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_chk_err", int'(chk_err), 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  task automatic pulse(input logic [NR-1:0] v, input logic [NR*W-1:0] dat);
    @(posedge clk); #1;
    req_valid = v; req_data = dat;
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0; fault = 1'b0;
    #2 check_reset_outs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request from id 1, operand 01.
    rsp_ready = 1'b1;
    pulse(4'b0010, 8'h04);
    repeat (2) @(posedge clk);
    #1;
    check("t1_rsp_valid", int'(rsp_valid), 1);
    check("t1_rsp_id", int'(rsp_id), 1);
    check("t1_rsp_data", int'(rsp_data), 2);
    wait_idle();

    // All four requesters valid with operands 00/01/10/11.
    @(posedge clk); #1;
    req_valid = 4'b1111; req_data = 8'hE4;
    repeat (16) @(posedge clk);
    #1 req_valid = '0;
    wait_idle();

    // Backpressure while other requesters are waiting.
    rsp_ready = 1'b0;
    pulse(4'b0001, 8'h03);
    repeat (2) @(posedge clk);
    #1 req_valid = 4'b1110;
    repeat (5) @(posedge clk);
    #1;
    check("t3_held_valid", int'(rsp_valid), 1);
    req_valid = '0; rsp_ready = 1'b1;
    wait_idle();

    // Serve id 3, then 0 and 3 together: pointer must wrap to 0.
    pulse(4'b1000, 8'h80);
    wait_idle();
    pulse(4'b1001, 8'h41);
    wait_idle();

    // Reset during DRIVE: everything dropped, search restarts at 0.
    pulse(4'b0100, 8'h10);
    #1 rst_n = 1'b0;
    #1 check_reset_outs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulse(4'b1111, 8'h1B);
    wait_idle();

    // Faulty inverter (bit 0 stuck low) on operand 10, then a clean op.
    fault = 1'b1;
    pulse(4'b0001, 8'h02);
    wait_idle();
    fault = 1'b0;
    pulse(4'b0010, 8'h08);
    wait_idle();
`ifdef BIN_INV_SCHED_CHECK_EN
    check("t6_chk_err", int'(chk_err), 1);
`else
    check("t6_chk_err", int'(chk_err), 0);
`endif

    // Randomized traffic with random backpressure and withdrawn requests.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      req_valid = NR'($urandom_range(0, 15));
      req_data  = (NR*W)'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    #0 req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1 check("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
